lock_sequencer: RTL and testbench
=================================

LOCK_SEQUENCER -- requirements
Module: lock_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50_000_000; inactivity cycles before return to IDLE.
REQ-002 SHALL have parameter MAX_FAILS, default 3; failed attempts before lockout.
REQ-003 SHALL have port clk  input  1  system clock; one clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port btn_valid  input  1  one-cycle pulse marking a colour press.
REQ-006 SHALL have port btn_color  input  2  pressed colour (RED=0, YELLOW=1, GREEN=2, BLUE=3), sampled only when btn_valid=1.
REQ-007 SHALL have port program  input  1  level request to enter/stay in programming.
REQ-008 SHALL have port state  output  4  registered state, encoding per REQ-011; feeds fsm_outputs.
REQ-009 SHALL have port unlocked  output  1  high while state=FOUR_CORRECT.
REQ-010 SHALL have port alarm  output  1  high while state=FOUR_WRONG or locked_out=1.

Function
REQ-011 SHALL encode states IDLE=0, ONE..FOUR_CORRECT=1..4, ONE..FOUR_WRONG=5..8, PROGRAM_MODE=9, ONE..FOUR_SET=10..13.
REQ-012 SHALL hold a 4-entry x 2-bit code store, code[0..3].
REQ-013 SHALL, on a press in IDLE, go to ONE_CORRECT if btn_color==code[0], else ONE_WRONG.
REQ-014 SHALL, on a press in k_CORRECT (k=1..3), go to (k+1)_CORRECT if btn_color==code[k], else (k+1)_WRONG.
REQ-015 SHALL, on a press in k_WRONG (k=1..3), go to (k+1)_WRONG regardless of colour.
REQ-016 SHALL ignore presses in FOUR_CORRECT and FOUR_WRONG; leave them only by timeout (to IDLE) or REQ-017.
REQ-017 SHALL go FOUR_CORRECT -> PROGRAM_MODE when program=1; program takes priority over a same-cycle press.
REQ-018 SHALL, on a press in PROGRAM_MODE / ONE_SET / TWO_SET / THREE_SET, write btn_color to code[0/1/2/3] on that edge and advance to ONE/TWO/THREE/FOUR_SET.
REQ-019 SHALL go FOUR_SET -> IDLE when program=0; presses in FOUR_SET ignored.
REQ-020 SHALL abort any SET/PROGRAM state to IDLE when program=0 before FOUR_SET, keeping entries already written.
REQ-021 SHALL reload an inactivity counter on every accepted press and every state change; in any non-IDLE state, counter reaching TIMEOUT_CYCLES-1 forces IDLE next edge.
REQ-022 SHALL increment a saturating fail counter on entry to FOUR_WRONG and clear it on entry to FOUR_CORRECT.
REQ-023 SHALL set locked_out when fail counter reaches MAX_FAILS; while locked_out, presses in IDLE are ignored until reset.
REQ-024 SHALL update state one edge after the sampled press (zero-cycle input-to-register latency; outputs visible the following cycle).
REQ-025 SHALL send illegal states 14, 15 to IDLE on the next edge.
REQ-026 SHALL derive unlocked and alarm combinationally from registered state/locked_out only (glitch-free w.r.t. inputs).

Reset
REQ-027 SHALL, on rst_n=0, asynchronously set state=IDLE, code={RED,YELLOW,GREEN,BLUE}, fail counter=0, locked_out=0, inactivity counter=0; hence unlocked=0, alarm=0.
REQ-028 SHALL abandon any in-progress entry or programming on reset mid-operation, with no partial code write.

Structure
REQ-029 SHALL take state and colour localparams from shared package lock_pkg, also used by fsm_outputs.
REQ-030 SHALL place the inactivity counter in sub-module inactivity_timer (inputs reload, enable; output expired).

Verification
REQ-031 SHALL test: after reset, presses R,Y,G,B -> states 1,2,3,4; unlocked=1 from cycle after 4th press.
REQ-032 SHALL test: presses R,G,G,B -> states 1,6,7,8; alarm=1; TIMEOUT_CYCLES idle cycles -> IDLE, alarm=0.
REQ-033 SHALL test: unlock, program=1, press B,B,R,G -> states 9,10..13; program=0 -> IDLE; B,B,R,G unlocks, R,Y,G,B fails.
REQ-034 SHALL test: MAX_FAILS=3 wrong sequences -> locked_out, alarm stays 1, correct code ignored until rst_n pulse.
REQ-035 SHALL test: rst_n asserted mid-programming after two SET writes -> code back to R,Y,G,B, state=IDLE immediately, no clock needed.
REQ-036 SHALL test: program=1 and btn_valid=1 same cycle in FOUR_CORRECT -> PROGRAM_MODE, code unchanged.

Source files
------------

// File: rtl/lock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lock_pkg
// Description : Shared state encodings, colour codes and types for the
//               colour-sequence lock (lock_sequencer, fsm_outputs).
// Revision    : 1.0 - initial release
// ============================================================================
package lock_pkg;

    typedef logic [3:0] state_t;
    typedef logic [1:0] color_t;

    // State encoding. The entry states are laid out so that a state number
    // equals the number of presses taken, with WRONG offset by four from
    // CORRECT, and the SET states follow PROGRAM_MODE in order.
    localparam state_t C_ST_IDLE          = 4'd0;
    localparam state_t C_ST_ONE_CORRECT   = 4'd1;
    localparam state_t C_ST_TWO_CORRECT   = 4'd2;
    localparam state_t C_ST_THREE_CORRECT = 4'd3;
    localparam state_t C_ST_FOUR_CORRECT  = 4'd4;
    localparam state_t C_ST_ONE_WRONG     = 4'd5;
    localparam state_t C_ST_TWO_WRONG     = 4'd6;
    localparam state_t C_ST_THREE_WRONG   = 4'd7;
    localparam state_t C_ST_FOUR_WRONG    = 4'd8;
    localparam state_t C_ST_PROGRAM_MODE  = 4'd9;
    localparam state_t C_ST_ONE_SET       = 4'd10;
    localparam state_t C_ST_TWO_SET       = 4'd11;
    localparam state_t C_ST_THREE_SET     = 4'd12;
    localparam state_t C_ST_FOUR_SET      = 4'd13;

    // Step between a k_CORRECT state and the (k+1)_WRONG state.
    localparam state_t C_CORRECT_TO_WRONG = 4'd5;

    localparam color_t C_RED    = 2'd0;
    localparam color_t C_YELLOW = 2'd1;
    localparam color_t C_GREEN  = 2'd2;
    localparam color_t C_BLUE   = 2'd3;

endpackage : lock_pkg
`default_nettype wire

// File: rtl/fsm_outputs.sv
`default_nettype none
// ============================================================================
// Module      : fsm_outputs
// Description : Output decode of the lock state machine. Driven only from
//               registered state, so outputs never glitch on input changes.
// Revision    : 1.0 - initial release
// Ports       : state      - registered FSM state
//               locked_out - registered lockout flag
//               unlocked   - high in FOUR_CORRECT
//               alarm      - high in FOUR_WRONG or while locked out
// ============================================================================
module fsm_outputs
    import lock_pkg::*;
(
    input  logic [3:0] state,
    input  logic       locked_out,
    output logic       unlocked,
    output logic       alarm
);

    always_comb begin
        unlocked = (state == C_ST_FOUR_CORRECT);
        alarm    = (state == C_ST_FOUR_WRONG) || locked_out;
    end

endmodule : fsm_outputs
`default_nettype wire

// File: rtl/inactivity_timer.sv
`default_nettype none
// ============================================================================
// Module      : inactivity_timer
// Description : Counts idle cycles while enabled and flags expiry once the
//               count reaches TIMEOUT_CYCLES-1. Cleared by reload or while
//               disabled.
// Revision    : 1.0 - initial release
// Ports       : clk     - system clock
//               rst_n   - asynchronous active-low reset
//               reload  - restart the count from zero
//               enable  - count only while high
//               expired - count has reached TIMEOUT_CYCLES-1 (while enabled)
// ============================================================================
module inactivity_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    input  logic enable,
    output logic expired
);

    localparam int unsigned C_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [C_CNT_W-1:0] r_count;

    // Holds at C_LAST so a blocked exit can never wrap and lose the expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (reload || !enable) begin
            r_count <= '0;
        end else if (r_count != C_LAST) begin
            r_count <= r_count + C_CNT_W'(1);
        end
    end

    assign expired = enable && (r_count == C_LAST);

endmodule : inactivity_timer
`default_nettype wire

// File: rtl/lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lock_sequencer
// Description : Four-press colour combination lock with reprogrammable code,
//               inactivity timeout and lockout after repeated failures.
// Revision    : 1.0 - initial release
// Ports       : clk         - system clock, all state on rising edge
//               rst_n       - asynchronous active-low reset
//               btn_valid   - one-cycle pulse marking a colour press
//               btn_color   - pressed colour, sampled with btn_valid
//               program_req - level request to enter/stay in programming
//               state       - registered FSM state
//               unlocked    - high while in FOUR_CORRECT
//               alarm       - high in FOUR_WRONG or while locked out
// ============================================================================
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned MAX_FAILS      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_valid,
    input  logic [1:0] btn_color,
    input  logic       program_req,
    output logic [3:0] state,
    output logic       unlocked,
    output logic       alarm
);

    localparam int unsigned C_FAIL_W = $clog2(MAX_FAILS + 1);
    localparam logic [C_FAIL_W-1:0] C_FAIL_MAX = C_FAIL_W'(MAX_FAILS);

    state_t              r_state;
    state_t              w_next_state;
    color_t              r_code [4];
    logic [C_FAIL_W-1:0] r_fail_cnt;
    logic [C_FAIL_W-1:0] w_fail_next;
    logic                r_locked_out;

    logic   w_accept;
    logic   w_code_we;
    color_t w_code_idx;
    logic   w_expired;
    logic   w_reload;
    logic   w_timer_en;
    logic   w_enter_open;
    logic   w_enter_alarm;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Illegal encodings and timeout dominate; otherwise
    // each group of states is handled by its numeric range.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_code_we    = 1'b0;
        // PROGRAM_MODE..THREE_SET (9..12) write code[0..3]; the low two
        // state bits plus three wrap to exactly that index.
        w_code_idx   = r_state[1:0] + 2'd3;

        if (r_state > C_ST_FOUR_SET) begin
            w_next_state = C_ST_IDLE;
        end else if (w_expired) begin
            w_next_state = C_ST_IDLE;
        end else if (r_state == C_ST_IDLE) begin
            if (btn_valid && !r_locked_out) begin
                w_accept     = 1'b1;
                w_next_state = (btn_color == r_code[0]) ? C_ST_ONE_CORRECT : C_ST_ONE_WRONG;
            end
        end else if (r_state <= C_ST_THREE_CORRECT) begin
            // In k_CORRECT the low bits equal k, the next code index to match.
            if (btn_valid) begin
                w_accept     = 1'b1;
                w_next_state = (btn_color == r_code[r_state[1:0]]) ?
                               r_state + 4'd1 : r_state + C_CORRECT_TO_WRONG;
            end
        end else if (r_state == C_ST_FOUR_CORRECT) begin
            if (program_req) begin
                w_next_state = C_ST_PROGRAM_MODE;
            end
        end else if (r_state <= C_ST_THREE_WRONG) begin
            if (btn_valid) begin
                w_accept     = 1'b1;
                w_next_state = r_state + 4'd1;
            end
        end else if (r_state == C_ST_FOUR_WRONG) begin
            w_next_state = r_state;
        end else if (r_state <= C_ST_THREE_SET) begin
            // Dropping the request aborts before any same-cycle write.
            if (!program_req) begin
                w_next_state = C_ST_IDLE;
            end else if (btn_valid) begin
                w_accept     = 1'b1;
                w_code_we    = 1'b1;
                w_next_state = r_state + 4'd1;
            end
        end else begin
            if (!program_req) begin
                w_next_state = C_ST_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    assign state = r_state;

    fsm_outputs u_fsm_outputs (
        .state      (r_state),
        .locked_out (r_locked_out),
        .unlocked   (unlocked),
        .alarm      (alarm)
    );

    // ------------------------------------------------------------------
    // Code store
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code[0] <= C_RED;
            r_code[1] <= C_YELLOW;
            r_code[2] <= C_GREEN;
            r_code[3] <= C_BLUE;
        end else if (w_code_we) begin
            r_code[w_code_idx] <= btn_color;
        end
    end

    // ------------------------------------------------------------------
    // Failure tracking and lockout
    // ------------------------------------------------------------------
    assign w_enter_open  = (w_next_state == C_ST_FOUR_CORRECT) && (r_state != C_ST_FOUR_CORRECT);
    assign w_enter_alarm = (w_next_state == C_ST_FOUR_WRONG) && (r_state != C_ST_FOUR_WRONG);

    always_comb begin
        w_fail_next = r_fail_cnt;
        if (w_enter_open) begin
            w_fail_next = '0;
        end else if (w_enter_alarm && (r_fail_cnt != C_FAIL_MAX)) begin
            w_fail_next = r_fail_cnt + C_FAIL_W'(1);
        end
    end

    // Lockout is sticky until reset; it is raised on the same edge that
    // enters the failing FOUR_WRONG.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_cnt   <= '0;
            r_locked_out <= 1'b0;
        end else begin
            r_fail_cnt   <= w_fail_next;
            r_locked_out <= r_locked_out | (w_fail_next == C_FAIL_MAX);
        end
    end

    // ------------------------------------------------------------------
    // Inactivity timeout
    // ------------------------------------------------------------------
    assign w_reload   = w_accept || (w_next_state != r_state);
    assign w_timer_en = (r_state != C_ST_IDLE);

    inactivity_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_inactivity_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .reload  (w_reload),
        .enable  (w_timer_en),
        .expired (w_expired)
    );

endmodule : lock_sequencer
`default_nettype wire

// File: tb/tb_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lock_sequencer
// Description : Self-checking bench for lock_sequencer. A behavioural model
//               tracks the lock in terms of presses taken, match so far and
//               programming progress; directed sequences pin the model with
//               literal expectations, then randomized traffic is compared
//               every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lock_sequencer;

    localparam int T_OUT  = 16;
    localparam int M_FAIL = 3;

    localparam logic [1:0] R = 2'd0;
    localparam logic [1:0] Y = 2'd1;
    localparam logic [1:0] G = 2'd2;
    localparam logic [1:0] B = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_valid = 1'b0;
    logic [1:0] btn_color = 2'd0;
    logic       program_req = 1'b0;
    logic [3:0] state;
    logic       unlocked;
    logic       alarm;

    int total = 0;
    int bad   = 0;

    lock_sequencer #(
        .TIMEOUT_CYCLES (T_OUT),
        .MAX_FAILS      (M_FAIL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_valid   (btn_valid),
        .btn_color   (btn_color),
        .program_req (program_req),
        .state       (state),
        .unlocked    (unlocked),
        .alarm       (alarm)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: kind 0 = idle, 1 = entering code (n presses so
    // far, ok = all matched), 2 = programming (n digits written).
    // ------------------------------------------------------------------
    int         m_kind = 0;
    int         m_n = 0;
    bit         m_ok = 1'b0;
    logic [1:0] m_code [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    int         m_fails = 0;
    bit         m_locked = 1'b0;
    int         m_since = 0;

    function automatic int exp_state();
        if (m_kind == 0) return 0;
        if (m_kind == 2) return 9 + m_n;
        return m_ok ? m_n : 4 + m_n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_kind = 0; m_n = 0; m_ok = 1'b0;
            m_code[0] = R; m_code[1] = Y; m_code[2] = G; m_code[3] = B;
            m_fails = 0; m_locked = 1'b0; m_since = 0;
        end else begin
            int prev;
            prev = exp_state();
            if (m_kind != 0 && m_since >= T_OUT - 1) begin
                m_kind = 0;
            end else if (m_kind == 0) begin
                if (btn_valid && !m_locked) begin
                    m_kind = 1; m_n = 1; m_ok = (btn_color == m_code[0]);
                end
            end else if (m_kind == 1) begin
                if (m_n < 4) begin
                    if (btn_valid) begin
                        m_ok = m_ok && (btn_color == m_code[m_n]);
                        m_n++;
                        if (m_n == 4) begin
                            if (m_ok) m_fails = 0;
                            else begin
                                if (m_fails < M_FAIL) m_fails++;
                                if (m_fails == M_FAIL) m_locked = 1'b1;
                            end
                        end
                    end
                end else if (m_ok && program_req) begin
                    m_kind = 2; m_n = 0;
                end
            end else begin
                if (!program_req) m_kind = 0;
                else if (m_n < 4 && btn_valid) begin
                    m_code[m_n] = btn_color;
                    m_n++;
                end
            end
            m_since = (exp_state() != prev) ? 0 : m_since + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            int es;
            es = exp_state();
            check("model_state", int'(state), es);
            check("model_unlocked", int'(unlocked), int'(es == 4));
            check("model_alarm", int'(alarm), int'(es == 8 || m_locked));
        end
    end

    // All tasks assume the caller sits 1 time unit after a rising edge.
    task automatic press(input logic [1:0] c);
        btn_valid = 1'b1;
        btn_color = c;
        @(posedge clk); #1;
        btn_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press4(input logic [1:0] a, input logic [1:0] b,
                          input logic [1:0] c, input logic [1:0] d,
                          input int s1, input int s2, input int s3, input int s4);
        press(a); check("seq_state1", int'(state), s1);
        press(b); check("seq_state2", int'(state), s2);
        press(c); check("seq_state3", int'(state), s3);
        press(d); check("seq_state4", int'(state), s4);
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        #23 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        check("rst_state", int'(state), 0);
        check("rst_unlocked", int'(unlocked), 0);
        check("rst_alarm", int'(alarm), 0);

        // Default code opens; timeout boundary from FOUR_CORRECT
        press4(R, Y, G, B, 1, 2, 3, 4);
        check("open_unlocked", int'(unlocked), 1);
        wait_cycles(T_OUT - 1);
        check("timeout_edge_minus1", int'(state), 4);
        wait_cycles(1);
        check("timeout_idle", int'(state), 0);

        // Wrong sequence raises alarm until timeout
        press4(R, G, G, B, 1, 6, 7, 8);
        check("wrong_alarm", int'(alarm), 1);
        wait_cycles(T_OUT);
        check("wrong_timeout_state", int'(state), 0);
        check("wrong_timeout_alarm", int'(alarm), 0);

        // Reprogram to B,B,R,G
        press4(R, Y, G, B, 1, 2, 3, 4);
        program_req = 1'b1;
        wait_cycles(1);
        check("prog_mode", int'(state), 9);
        press4(B, B, R, G, 10, 11, 12, 13);
        press(Y);
        check("four_set_ignores", int'(state), 13);
        program_req = 1'b0;
        wait_cycles(1);
        check("prog_exit", int'(state), 0);
        press4(B, B, R, G, 1, 2, 3, 4);
        check("new_code_unlocked", int'(unlocked), 1);
        wait_cycles(T_OUT);
        press4(R, Y, G, B, 5, 6, 7, 8);
        check("old_code_alarm", int'(alarm), 1);
        wait_cycles(T_OUT);

        // program and press in the same cycle: program wins, no write
        press4(B, B, R, G, 1, 2, 3, 4);
        program_req = 1'b1;
        press(R);
        check("prog_priority", int'(state), 9);
        program_req = 1'b0;
        wait_cycles(1);
        check("prog_abort", int'(state), 0);
        press4(B, B, R, G, 1, 2, 3, 4);
        wait_cycles(T_OUT);

        // Asynchronous reset in the middle of programming
        press4(B, B, R, G, 1, 2, 3, 4);
        program_req = 1'b1;
        wait_cycles(1);
        press(Y);
        press(Y);
        check("mid_prog_state", int'(state), 11);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_state", int'(state), 0);
        check("async_rst_alarm", int'(alarm), 0);
        #1 rst_n = 1'b1;
        program_req = 1'b0;
        @(posedge clk); #1;
        press4(R, Y, G, B, 1, 2, 3, 4);
        wait_cycles(T_OUT);

        // Lockout after MAX_FAILS wrong sequences
        for (int i = 0; i < M_FAIL; i++) begin
            press4(G, G, G, G, 5, 6, 7, 8);
            wait_cycles(T_OUT);
        end
        check("lock_state", int'(state), 0);
        check("lock_alarm", int'(alarm), 1);
        press(R); check("lock_ignore1", int'(state), 0);
        press(Y); check("lock_ignore2", int'(state), 0);
        press(G); check("lock_ignore3", int'(state), 0);
        press(B); check("lock_ignore4", int'(state), 0);
        check("lock_alarm_hold", int'(alarm), 1);
        reset_pulse();
        check("lock_cleared", int'(alarm), 0);
        press4(R, Y, G, B, 1, 2, 3, 4);
        wait_cycles(T_OUT);

        // Randomized traffic against the model
        begin
            bit quiet;
            quiet = 1'b0;
            for (int cyc = 0; cyc < 4000; cyc++) begin
                if (cyc % 64 == 0) quiet = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 399) == 0) begin
                    btn_valid = 1'b0;
                    reset_pulse();
                end else begin
                    btn_valid = !quiet && ($urandom_range(0, 2) == 0);
                    if (m_kind == 1 && m_n < 4 && $urandom_range(0, 9) < 7)
                        btn_color = m_code[m_n];
                    else if (m_kind == 0 && $urandom_range(0, 9) < 7)
                        btn_color = m_code[0];
                    else
                        btn_color = 2'($urandom_range(0, 3));
                    if (m_kind == 2 || (m_kind == 1 && m_n == 4 && m_ok))
                        program_req = ($urandom_range(0, 19) != 0);
                    else
                        program_req = ($urandom_range(0, 3) == 0);
                    @(posedge clk); #1;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_lock_sequencer
`default_nettype wire
